// File: rtl/pc_unit32_pkg.sv
// Shared definitions for the PC unit: FSM state encoding, reset vector and
// the control bundle that selects the next PC.
package pc_unit32_pkg;

   typedef enum logic {
      FETCH = 1'b0,
      EXEC  = 1'b1
   } state_t;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic branch;
      logic nbranch;
      logic jmp;
      logic jal;
      logic jr;
   } pc_ctrl_t;

   // Conditional branch resolution: beq takes on Zero, bne takes on ~Zero.
   function automatic logic branch_taken(input pc_ctrl_t c, input logic zero);
      return (c.branch & zero) | (c.nbranch & ~zero);
   endfunction

endpackage

// File: rtl/pc_unit32_next.sv
// Combinational next-PC selection: jr > j/jal > taken branch > sequential.
module pc_next32
   import pc_unit32_pkg::*;
(
   input  logic [31:0] i_pc_plus_4,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_addr_result,
   input  logic [31:0] i_rd1,
   input  logic        i_zero,
   input  pc_ctrl_t    i_ctrl,
   output logic [31:0] o_next_pc
);

   logic [31:0] w_jump_target;
   logic [31:0] w_jr_target;
   logic        w_unused;

   assign w_jump_target = {i_pc_plus_4[31:28], i_instr[25:0], 2'b00};
   assign w_jr_target   = {i_rd1[31:2], 2'b00};
   assign w_unused      = ^{i_rd1[1:0], i_instr[31:26]};

   always_comb begin
      o_next_pc = i_pc_plus_4;
      if (i_ctrl.jr) begin
         o_next_pc = w_jr_target;
      end else if (i_ctrl.jmp || i_ctrl.jal) begin
         o_next_pc = w_jump_target;
      end else if (branch_taken(i_ctrl, i_zero)) begin
         o_next_pc = i_addr_result;
      end
   end

endmodule

// File: rtl/pc_unit32.sv
// Two-state fetch/execute PC unit: fetches one instruction, holds it in EXEC
// until commit, then updates pc, link register and retired-instruction count.
module pc_unit32
   import pc_unit32_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] Addr_Result,
   input  logic        Zero,
   input  logic [31:0] Read_data_1,
   input  logic        Branch,
   input  logic        nBranch,
   input  logic        Jmp,
   input  logic        Jal,
   input  logic        Jr,
   input  logic        stall,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic        imem_req,
   output logic [31:0] pc,
   output logic [31:0] Instruction,
   output logic [31:0] PC_plus_4,
   output logic [31:0] link_addr,
   output logic        instr_valid,
   output logic [31:0] retired_cnt
);

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_link;
   logic [31:0] r_retired_cnt;
   logic [31:0] w_pc_plus_4;
   logic [31:0] w_next_pc;
   pc_ctrl_t    w_ctrl;

   assign w_pc_plus_4 = r_pc + 32'd4;
   assign w_ctrl      = '{branch: Branch, nbranch: nBranch, jmp: Jmp, jal: Jal, jr: Jr};

   pc_next32 u_pc_next (
      .i_pc_plus_4   (w_pc_plus_4),
      .i_instr       (r_instr),
      .i_addr_result (Addr_Result),
      .i_rd1         (Read_data_1),
      .i_zero        (Zero),
      .i_ctrl        (w_ctrl),
      .o_next_pc     (w_next_pc)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= FETCH;
         r_pc          <= RESET_PC;
         r_instr       <= '0;
         r_link        <= '0;
         r_retired_cnt <= '0;
      end else begin
         unique case (r_state)
            FETCH: begin
               if (imem_ready) begin
                  r_instr <= imem_rdata;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               // Control inputs only matter on the commit edge.
               if (!stall) begin
                  r_pc          <= w_next_pc;
                  r_retired_cnt <= r_retired_cnt + 32'd1;
                  if (Jal) begin
                     r_link <= w_pc_plus_4;
                  end
                  r_state <= FETCH;
               end
            end
            default: r_state <= FETCH;
         endcase
      end
   end

   assign imem_req    = (r_state == FETCH);
   assign instr_valid = (r_state == EXEC);
   assign pc          = r_pc;
   assign Instruction = r_instr;
   assign PC_plus_4   = w_pc_plus_4;
   assign link_addr   = r_link;
   assign retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_pc_unit32.sv
// Directed table-driven bench for pc_unit32 plus hand sequences for reset
// and retired-count wrap.
module tb_pc_unit32;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] Addr_Result, Read_data_1, imem_rdata;
   logic        Zero, Branch, nBranch, Jmp, Jal, Jr, stall, imem_ready;
   logic        imem_req, instr_valid;
   logic [31:0] pc, Instruction, PC_plus_4, link_addr, retired_cnt;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   pc_unit32 dut (
      .clock       (clock),
      .reset       (reset),
      .Addr_Result (Addr_Result),
      .Zero        (Zero),
      .Read_data_1 (Read_data_1),
      .Branch      (Branch),
      .nBranch     (nBranch),
      .Jmp         (Jmp),
      .Jal         (Jal),
      .Jr          (Jr),
      .stall       (stall),
      .imem_rdata  (imem_rdata),
      .imem_ready  (imem_ready),
      .imem_req    (imem_req),
      .pc          (pc),
      .Instruction (Instruction),
      .PC_plus_4   (PC_plus_4),
      .link_addr   (link_addr),
      .instr_valid (instr_valid),
      .retired_cnt (retired_cnt)
   );

   always #5 clock = ~clock;

   // ctrl bit order: {Branch, nBranch, Jmp, Jal, Jr}
   typedef struct {
      int unsigned wait_cyc;
      int unsigned stall_cyc;
      logic [31:0] rdata;
      logic [4:0]  ctrl;
      logic        zero;
      logic [31:0] addr;
      logic [31:0] rd1;
      logic [31:0] exp_pc;
      logic [31:0] exp_link;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_ctrl();
      {Branch, nBranch, Jmp, Jal, Jr} = 5'b0;
      Zero = 1'b0; Addr_Result = '0; Read_data_1 = '0;
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Runs one full fetch/exec transaction; assumes FETCH at a negedge.
   task automatic run_vec(input vec_t v, input int idx);
      logic [31:0] prev_pc, prev_cnt;
      prev_pc  = pc;
      prev_cnt = retired_cnt;
      chk($sformatf("v%0d_req", idx), {31'b0, imem_req}, 32'd1);
      for (int unsigned w = 0; w < v.wait_cyc; w++) begin
         imem_ready = 1'b0; imem_rdata = 32'hBAD0_0000 + w;
         tick();
         chk($sformatf("v%0d_wait%0d_valid", idx, w), {31'b0, instr_valid}, 32'd0);
      end
      imem_ready = 1'b1; imem_rdata = v.rdata;
      tick();
      chk($sformatf("v%0d_valid", idx), {31'b0, instr_valid}, 32'd1);
      chk($sformatf("v%0d_req_exec", idx), {31'b0, imem_req}, 32'd0);
      chk($sformatf("v%0d_instr", idx), Instruction, v.rdata);
      // Garbage on memory and control while stalled must be ignored.
      imem_rdata = 32'hFFFF_FFFF;
      for (int unsigned s = 0; s < v.stall_cyc; s++) begin
         stall = 1'b1; Jr = 1'b1; Jal = 1'b1; Read_data_1 = 32'hDEAD_BEEF;
         tick();
         chk($sformatf("v%0d_stall%0d_pc", idx, s), pc, prev_pc);
         chk($sformatf("v%0d_stall%0d_cnt", idx, s), retired_cnt, prev_cnt);
         chk($sformatf("v%0d_stall%0d_instr", idx, s), Instruction, v.rdata);
         chk($sformatf("v%0d_stall%0d_valid", idx, s), {31'b0, instr_valid}, 32'd1);
      end
      stall = 1'b0;
      {Branch, nBranch, Jmp, Jal, Jr} = v.ctrl;
      Zero = v.zero; Addr_Result = v.addr; Read_data_1 = v.rd1;
      tick();
      clear_ctrl();
      imem_ready = 1'b0;
      chk($sformatf("v%0d_pc", idx), pc, v.exp_pc);
      chk($sformatf("v%0d_pc4", idx), PC_plus_4, v.exp_pc + 32'd4);
      chk($sformatf("v%0d_link", idx), link_addr, v.exp_link);
      chk($sformatf("v%0d_cnt", idx), retired_cnt, v.exp_cnt);
      chk($sformatf("v%0d_fetch", idx), {30'b0, imem_req, instr_valid}, 32'd2);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_pc"},    pc,          32'h0);
      chk({tag, "_cnt"},   retired_cnt, 32'h0);
      chk({tag, "_link"},  link_addr,   32'h0);
      chk({tag, "_instr"}, Instruction, 32'h0);
      chk({tag, "_pc4"},   PC_plus_4,   32'h4);
      chk({tag, "_req"},   {31'b0, imem_req},    32'd1);
      chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      //           wait stall rdata          ctrl      z     addr           rd1            exp_pc         exp_link       cnt
      vecs[0]  = '{0, 0, 32'h2000_0001, 5'b00000, 1'b0, 32'h0,         32'h0,         32'h0000_0004, 32'h0,         32'd1};
      vecs[1]  = '{0, 0, 32'h2000_0002, 5'b00000, 1'b0, 32'h0,         32'h0,         32'h0000_0008, 32'h0,         32'd2};
      vecs[2]  = '{0, 0, 32'h2000_0003, 5'b00000, 1'b0, 32'h0,         32'h0,         32'h0000_000C, 32'h0,         32'd3};
      vecs[3]  = '{0, 0, 32'h2000_0004, 5'b00000, 1'b0, 32'h0,         32'h0,         32'h0000_0010, 32'h0,         32'd4};
      vecs[4]  = '{0, 0, 32'h1000_000B, 5'b10000, 1'b1, 32'h0000_0040, 32'h0,         32'h0000_0040, 32'h0,         32'd5};
      vecs[5]  = '{0, 0, 32'h1400_000F, 5'b01000, 1'b1, 32'h0000_0080, 32'h0,         32'h0000_0044, 32'h0,         32'd6};
      vecs[6]  = '{0, 0, 32'h0000_0008, 5'b00001, 1'b0, 32'h0,         32'h0040_0020, 32'h0040_0020, 32'h0,         32'd7};
      vecs[7]  = '{0, 0, 32'h0C10_0000, 5'b10010, 1'b1, 32'h0000_1234, 32'h0,         32'h0040_0000, 32'h0040_0024, 32'd8};
      vecs[8]  = '{0, 0, 32'h0800_0040, 5'b00101, 1'b0, 32'h0,         32'h0040_0027, 32'h0040_0024, 32'h0040_0024, 32'd9};
      vecs[9]  = '{3, 4, 32'h2000_0009, 5'b00000, 1'b0, 32'h0,         32'h0,         32'h0040_0028, 32'h0040_0024, 32'd10};
      vecs[10] = '{0, 0, 32'h1400_0010, 5'b01000, 1'b0, 32'h0000_1000, 32'h0,         32'h0000_1000, 32'h0040_0024, 32'd11};
      vecs[11] = '{0, 0, 32'h1000_0010, 5'b10000, 1'b0, 32'h0000_5555, 32'h0,         32'h0000_1004, 32'h0040_0024, 32'd12};
      vecs[12] = '{1, 1, 32'h1000_0020, 5'b10000, 1'b1, 32'hF000_0010, 32'h0,         32'hF000_0010, 32'h0040_0024, 32'd13};
      vecs[13] = '{0, 0, 32'h0BFF_FFFF, 5'b00100, 1'b0, 32'h0,         32'h0,         32'hFFFF_FFFC, 32'h0040_0024, 32'd14};
      vecs[14] = '{0, 0, 32'h2000_000E, 5'b00000, 1'b0, 32'h0,         32'h0,         32'h0000_0000, 32'h0040_0024, 32'd15};
      vecs[15] = '{0, 0, 32'h2000_000F, 5'b00000, 1'b0, 32'h0,         32'h0,         32'h0000_0004, 32'h0040_0024, 32'd16};

      reset = 1'b1; stall = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
      clear_ctrl();
      tick();
      tick();
      reset = 1'b0;
      check_reset_state("por");

      for (int i = 0; i < 16; i++) begin
         run_vec(vecs[i], i);
      end

      // Reset while waiting in FETCH.
      imem_ready = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_state("rst_fetch");

      // Advance once so pc/count are nonzero, then reset during a stalled EXEC.
      v = '{0, 0, 32'h2000_0011, 5'b00000, 1'b0, 32'h0, 32'h0, 32'h4, 32'h0, 32'd1};
      run_vec(v, 100);
      imem_ready = 1'b1; imem_rdata = 32'h2000_0012;
      tick();
      chk("rst_exec_pre_valid", {31'b0, instr_valid}, 32'd1);
      stall = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; stall = 1'b0; imem_ready = 1'b0;
      check_reset_state("rst_exec");

      // Retired counter rollover from a preloaded value.
      force dut.r_retired_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.r_retired_cnt;
      v = '{0, 0, 32'h2000_0013, 5'b00000, 1'b0, 32'h0, 32'h0, 32'h4, 32'h0, 32'hFFFF_FFFF};
      run_vec(v, 101);
      v = '{0, 0, 32'h2000_0014, 5'b00000, 1'b0, 32'h0, 32'h0, 32'h8, 32'h0, 32'h0000_0000};
      run_vec(v, 102);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
